reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_if.sv | 27 ++
 rtl/reg_write_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle between two register-file writers, the arbiter and the 5x32 write decoder.
interface reg_write_arbiter_if;
    logic        hold;
    logic        req_a;
    logic [4:0]  addr_a;
    logic [31:0] data_a;
    logic        req_b;
    logic [4:0]  addr_b;
    logic [31:0] data_b;
    logic        gnt_a;
    logic        gnt_b;
    logic [4:0]  we_sel;
    logic [31:0] we_onehot;
    logic [31:0] wdata;
    logic        wvalid;
    logic        busy;

    modport master (
        output hold, req_a, addr_a, data_a, req_b, addr_b, data_b,
        input  gnt_a, gnt_b, we_sel, we_onehot, wdata, wvalid, busy
    );

    modport slave (
        input  hold, req_a, addr_a, data_a, req_b, addr_b, data_b,
        output gnt_a, gnt_b, we_sel, we_onehot, wdata, wvalid, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for two register-file writers; registers the winner's address,
// data and one-hot write enable so one write can retire per cycle.
module reg_write_arbiter #(
    parameter bit R0_PROTECT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;
    logic        wvalid_q, wvalid_d;
    logic [4:0]  we_sel_q, we_sel_d;
    logic [31:0] we_onehot_q, we_onehot_d;
    logic [31:0] wdata_q, wdata_d;

    logic        any_req;
    logic        pick_b;
    logic        can_grant;
    logic [4:0]  win_addr;
    logic [31:0] win_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= LAST_B;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            wvalid_q    <= 1'b0;
            we_sel_q    <= 5'd0;
            we_onehot_q <= 32'd0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            wvalid_q    <= wvalid_d;
            we_sel_q    <= we_sel_d;
            we_onehot_q <= we_onehot_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        wvalid_d    = 1'b0;
        we_sel_d    = we_sel_q;
        we_onehot_d = 32'd0;
        wdata_d     = wdata_q;

        any_req   = bus.req_a | bus.req_b;
        // B wins only when it is alone, or on a tie when A was the previous winner.
        pick_b    = bus.req_b & (~bus.req_a | (last_q == LAST_A));
        win_addr  = pick_b ? bus.addr_b : bus.addr_a;
        win_data  = pick_b ? bus.data_b : bus.data_a;
        can_grant = (state_q != STALL) & ~bus.hold & any_req;

        case (state_q)
            IDLE, WRITE: begin
                if (bus.hold)
                    state_d = STALL;
                else if (any_req)
                    state_d = WRITE;
                else
                    state_d = IDLE;
            end
            STALL: begin
                if (!bus.hold)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (can_grant) begin
            gnt_a_d  = ~pick_b;
            gnt_b_d  = pick_b;
            wvalid_d = 1'b1;
            last_d   = pick_b ? LAST_B : LAST_A;
            we_sel_d = win_addr;
            wdata_d  = win_data;
            // Register 0 is hardwired, so its write still handshakes but enables nothing.
            if (!(R0_PROTECT && (win_addr == 5'd0)))
                we_onehot_d = 32'd1 << win_addr;
        end
    end

    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.we_sel    = we_sel_q;
    assign bus.we_onehot = we_onehot_q;
    assign bus.wdata     = wdata_q;
    assign bus.busy      = (bus.req_a & ~gnt_a_q) | (bus.req_b & ~gnt_b_q)
                         | (bus.hold & any_req);
endmodule
